// File: rtl/piso_serializer_if.sv
// Word-in / bit-out stream bundle for piso_serializer.
// master: producer/consumer side; slave: the serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             dout;
    logic             dout_valid;
    logic             dout_sof;
    logic             dout_eof;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, dout, dout_valid, dout_sof, dout_eof, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, dout, dout_valid, dout_sof, dout_eof, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out converter with valid/ready word input and
// framed serial output (sof/eof). Back-to-back words stream without a gap.
// Optional macro PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst,
    piso_serializer_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             load_slot;
    logic             accept;
    logic             din_ready_c;
    logic             dout_c;
    logic             dout_valid_c;
    logic             dout_sof_c;
    logic             dout_eof_c;
    logic             busy_c;

`ifdef PISO_PARITY_EN
    logic par;
`endif

    assign last_bit = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));

    // A new word may be loaded in the final cycle of the current frame.
`ifdef PISO_PARITY_EN
    assign load_slot = (state == PARITY);
`else
    assign load_slot = last_bit;
`endif

    assign accept = bus.din_valid & din_ready_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef PISO_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = accept ? SHIFT : IDLE;
`endif
                end
            end
            PARITY: begin
`ifdef PISO_PARITY_EN
                state_nx = accept ? SHIFT : IDLE;
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shift register and bit counter; the counter holds at WIDTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= bus.din;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
            if (!last_bit) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef PISO_PARITY_EN
    // Even parity of the word, captured on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^bus.din;
        end
    end
`endif

    // Output decode from registered state only; din_ready is held low in reset.
    always_comb begin
        din_ready_c  = 1'b0;
        dout_c       = 1'b0;
        dout_valid_c = 1'b0;
        dout_sof_c   = 1'b0;
        dout_eof_c   = 1'b0;
        busy_c       = 1'b0;
        din_ready_c  = !rst && ((state == IDLE) || load_slot);
        if (state == SHIFT) begin
            dout_c       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
            dout_valid_c = 1'b1;
            dout_sof_c   = (cnt == '0);
            busy_c       = 1'b1;
`ifndef PISO_PARITY_EN
            dout_eof_c   = last_bit;
`endif
        end
`ifdef PISO_PARITY_EN
        if (state == PARITY) begin
            dout_c       = par;
            dout_valid_c = 1'b1;
            dout_eof_c   = 1'b1;
            busy_c       = 1'b1;
        end
`endif
    end

    assign bus.din_ready  = din_ready_c;
    assign bus.dout       = dout_c;
    assign bus.dout_valid = dout_valid_c;
    assign bus.dout_sof   = dout_sof_c;
    assign bus.dout_eof   = dout_eof_c;
    assign bus.busy       = busy_c;
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: one MSB-first and one LSB-first
// instance share the same word stream; a negedge monitor checks every cycle.
module tb_piso_serializer;
    localparam int unsigned WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef struct packed {
        logic d;
        logic sof;
        logic eof;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;

    exp_t q0[$];
    exp_t q1[$];
    bit   in_frame[2];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(WIDTH)) m_if ();
    piso_serializer_if #(.WIDTH(WIDTH)) l_if ();

    assign m_if.din       = din;
    assign m_if.din_valid = din_valid;
    assign l_if.din       = din;
    assign l_if.din_valid = din_valid;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (l_if.slave)
    );

    // Expected frame of a word for both bit orders.
    function automatic void push_word(input logic [WIDTH-1:0] w);
        exp_t e;
        for (int i = 0; i < int'(WIDTH); i++) begin
            e.sof = (i == 0);
            e.eof = !PARITY_EN && (i == int'(WIDTH) - 1);
            e.d   = w[WIDTH-1-i];
            q0.push_back(e);
            e.d   = w[i];
            q1.push_back(e);
        end
        if (PARITY_EN) begin
            e.d   = ^w;
            e.sof = 1'b0;
            e.eof = 1'b1;
            q0.push_back(e);
            q1.push_back(e);
        end
    endfunction

    task automatic check_lane(input int idx, input logic v, input logic d, input logic s,
                              input logic e, input logic r, input logic b);
        exp_t x;
        vectors++;
        if (rst) begin
            if (r !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_ready lane%0d: din_ready=%b required 0", idx, r);
            end
            if (idx == 0) q0.delete();
            else          q1.delete();
            in_frame[idx] = 1'b0;
            return;
        end
        if (v) begin
            if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
                miscompares++;
                $display("FAIL unexpected_bit lane%0d at %0t: dout_valid=1 required 0", idx, $time);
                return;
            end
            if (idx == 0) x = q0.pop_front();
            else          x = q1.pop_front();
            if ({d, s, e, r, b} !== {x.d, x.sof, x.eof, x.eof, 1'b1}) begin
                miscompares++;
                $display("FAIL bit lane%0d at %0t: {dout,sof,eof,ready,busy}=%b required %b",
                         idx, $time, {d, s, e, r, b}, {x.d, x.sof, x.eof, x.eof, 1'b1});
            end
            in_frame[idx] = !x.eof;
        end else begin
            if ({d, s, e, r, b, in_frame[idx]} !== 6'b000100) begin
                miscompares++;
                $display("FAIL idle lane%0d at %0t: {dout,sof,eof,ready,busy,gap}=%b required 000100",
                         idx, $time, {d, s, e, r, b, in_frame[idx]});
            end
            in_frame[idx] = 1'b0;
        end
    endtask

    // Monitor: compare both lanes every cycle, away from the active edge.
    always @(negedge clk) begin
        check_lane(0, m_if.dout_valid, m_if.dout, m_if.dout_sof, m_if.dout_eof,
                   m_if.din_ready, m_if.busy);
        check_lane(1, l_if.dout_valid, l_if.dout, l_if.dout_sof, l_if.dout_eof,
                   l_if.din_ready, l_if.busy);
    end

    // Offer a word, wait for accept, then check first-bit latency. din_valid stays high.
    task automatic send(input logic [WIDTH-1:0] w);
        bit got = 1'b0;
        push_word(w);
        din       = w;
        din_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (m_if.din_ready) got = 1'b1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout word %h: din_ready=0 required 1", w);
            din_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if ({m_if.dout_valid, m_if.dout_sof, l_if.dout_valid, l_if.dout_sof} !== 4'b1111) begin
            miscompares++;
            $display("FAIL latency word %h: {valid,sof msb,valid,sof lsb}=%b required 1111",
                     w, {m_if.dout_valid, m_if.dout_sof, l_if.dout_valid, l_if.dout_sof});
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Toggle din_valid and scramble din while the frame is mid-shift.
    task automatic stall();
        repeat (5) begin
            @(posedge clk);
            #1;
            din_valid = ~din_valid;
            din       = din + 8'h3D;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(2);

        // Single word from IDLE.
        send(8'hA5);
        din_valid = 1'b0;
        wait_cycles(12);

        // Back-to-back words with din_valid held high.
        send(8'hA5);
        send(8'h3C);
        din_valid = 1'b0;
        wait_cycles(22);

        // Stall: handshake noise during the frame must not disturb it.
        send(8'hA5);
        stall();
        send(8'h1E);
        din_valid = 1'b0;
        wait_cycles(24);

        // Odd-parity word, asymmetric under bit reversal.
        send(8'h07);
        din_valid = 1'b0;
        wait_cycles(12);

        // Reset in cycle 4 of a frame, then an immediate new word.
        send(8'hFF);
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h1E);
        din_valid = 1'b0;
        wait_cycles(14);

        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: expected bits pending msb=%0d lsb=%0d required 0",
                     q0.size(), q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
